// File: rtl/tank_pkg.sv
// Shared tank/bullet geometry, arbiter FSM states and small spawn helpers.
// Pure definitions, no state; the collision checker uses the same constants.
// Pose math carries two extra bits so both underflow and >255 show up in bits [9:8].
package tank_pkg;

    localparam int N_SLOTS        = 8;
    localparam int SLOT_W         = 3;
    localparam int MAX_PER_PLAYER = 4;
    localparam int COOLDOWN       = 12;
    localparam int PEND_TIMEOUT   = 16;

    localparam int TANK_W      = 3;
    localparam int TANK_H      = 4;
    localparam int BULLET_SIZE = 2;
    // Vertical offset that centres a horizontal shot on the tank body
    localparam int SIDE_OFS    = (TANK_H - BULLET_SIZE) / 2;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARB    = 2'd1,
        ST_SPAWN  = 2'd2,
        ST_SETTLE = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic       ok;
        logic [7:0] x;
        logic [7:0] y;
    } pose_t;

    // Bullet spawn position from tank top-left and firing direction
    function automatic pose_t calc_spawn(input logic [7:0] x, input logic [7:0] y,
                                         input logic [1:0] dir);
        logic [9:0] vx;
        logic [9:0] vy;
        pose_t      p;
        vx = {2'b00, x};
        vy = {2'b00, y};
        case (dir)
            DIR_UP:    vy = vy - 10'(BULLET_SIZE);
            DIR_RIGHT: begin
                vx = vx + 10'(TANK_W);
                vy = vy + 10'(SIDE_OFS);
            end
            DIR_DOWN:  vy = vy + 10'(TANK_H);
            DIR_LEFT:  begin
                vx = vx - 10'(BULLET_SIZE);
                vy = vy + 10'(SIDE_OFS);
            end
            default: ;
        endcase
        p.ok = ~|{vx[9:8], vy[9:8]};
        p.x  = vx[7:0];
        p.y  = vy[7:0];
        return p;
    endfunction

    function automatic logic [3:0] popcount(input logic [N_SLOTS-1:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < N_SLOTS; i++) c = c + {3'b000, v[i]};
        return c;
    endfunction

    // Index of the lowest set bit (0 when none set; callers qualify with |v)
    function automatic logic [SLOT_W-1:0] lowest_set(input logic [N_SLOTS-1:0] v);
        logic [SLOT_W-1:0] s;
        s = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) if (v[i]) s = SLOT_W'(i);
        return s;
    endfunction

endpackage

// File: rtl/fire_req_ctrl.sv
// Per-player fire request tracker: pending flag, latched dir, cooldown and pending-timeout timers.
// Capture takes effect the cycle after the fire pulse; ack/drop are combinational 1-cycle pulses.
// No backpressure: fire pulses are dropped silently while pending, in cooldown or dead.
module fire_req_ctrl
    import tank_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       game_tick,
    input  logic       fire,
    input  logic       alive,
    input  logic [1:0] fire_dir,
    input  logic       busy,       // arbiter is currently serving this player
    input  logic       grant,      // spawn handshake for this player
    input  logic       pose_drop,  // arbiter rejected the spawn pose
    output logic       pend,
    output logic [1:0] pend_dir,
    output logic       ack,
    output logic       drop
);

    localparam logic [3:0] CD_LOAD  = 4'(COOLDOWN);
    localparam logic [4:0] TOUT_MAX = 5'(PEND_TIMEOUT);

    logic [3:0] cooldown;
    logic [4:0] tout;

    // Discard conditions; death and timeout are ignored once the arbiter owns the request
    always_comb begin
        ack  = grant;
        drop = pose_drop || (pend && !busy && (!alive || tout == TOUT_MAX));
    end

    // Request flag, latched direction and the two game_tick timers
    always_ff @(posedge clk) begin
        if (rst) begin
            pend     <= 1'b0;
            pend_dir <= 2'd0;
            cooldown <= 4'd0;
            tout     <= 5'd0;
        end else begin
            if (game_tick && cooldown != 4'd0)
                cooldown <= cooldown - 4'd1;
            if (game_tick && pend && !busy && tout != TOUT_MAX)
                tout <= tout + 5'd1;
            if (grant) begin
                pend     <= 1'b0;
                cooldown <= CD_LOAD;
            end else if (drop) begin
                pend <= 1'b0;
            end else if (fire && alive && cooldown == 4'd0 && !pend) begin
                pend     <= 1'b1;
                pend_dir <= fire_dir;
                tout     <= 5'd0;
            end
        end
    end

endmodule

// File: rtl/bullet_slot_arbiter.sv
// Shares the 8-slot bullet pool between P1/P2: picks a free slot, computes spawn pose, owns bullet_owner.
// Fire pulse at t -> spawn_valid at t+3 earliest; ack in the same cycle as the accepting spawn_ready.
// spawn_* held stable while spawn_ready is low; requests wait (up to the timeout) for a slot.
module bullet_slot_arbiter
    import tank_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       game_tick,
    input  logic       p1_fire,
    input  logic       p2_fire,
    input  logic [7:0] p1_x,
    input  logic [7:0] p1_y,
    input  logic [7:0] p2_x,
    input  logic [7:0] p2_y,
    input  logic [1:0] p1_dir,
    input  logic [1:0] p2_dir,
    input  logic       p1_alive,
    input  logic       p2_alive,
    input  logic [7:0] bullet_active,
    output logic       spawn_valid,
    input  logic       spawn_ready,
    output logic [2:0] spawn_slot,
    output logic [7:0] spawn_x,
    output logic [7:0] spawn_y,
    output logic [1:0] spawn_dir,
    output logic [7:0] bullet_owner,
    output logic       p1_ack,
    output logic       p2_ack,
    output logic       p1_drop,
    output logic       p2_drop
);

    arb_state_t state;
    arb_state_t state_next;

    logic       rr_last;      // player granted most recently, 0=P1 1=P2
    logic       spawn_owner;  // player being served in SPAWN
    logic       p1_pend, p2_pend;
    logic [1:0] p1_pend_dir, p2_pend_dir;

    logic [7:0] free;
    logic       any_free;
    logic [2:0] free_slot;
    logic [3:0] p1_count, p2_count;
    logic       p1_elig, p2_elig, any_elig, pick;
    logic [7:0] pick_x, pick_y;
    logic [1:0] pick_dir;
    pose_t      pose;

    logic       handshake, arb_load;
    logic       p1_busy, p2_busy, p1_grant, p2_grant, p1_pose_drop, p2_pose_drop;

    fire_req_ctrl u_p1 (
        .clk(clk), .rst(rst), .game_tick(game_tick),
        .fire(p1_fire), .alive(p1_alive), .fire_dir(p1_dir),
        .busy(p1_busy), .grant(p1_grant), .pose_drop(p1_pose_drop),
        .pend(p1_pend), .pend_dir(p1_pend_dir), .ack(p1_ack), .drop(p1_drop)
    );

    fire_req_ctrl u_p2 (
        .clk(clk), .rst(rst), .game_tick(game_tick),
        .fire(p2_fire), .alive(p2_alive), .fire_dir(p2_dir),
        .busy(p2_busy), .grant(p2_grant), .pose_drop(p2_pose_drop),
        .pend(p2_pend), .pend_dir(p2_pend_dir), .ack(p2_ack), .drop(p2_drop)
    );

    // Slot availability, per-player caps, round-robin pick and pose of the picked player
    always_comb begin
        free      = ~bullet_active;
        any_free  = |free;
        free_slot = lowest_set(free);
        p1_count  = popcount(bullet_active & ~bullet_owner);
        p2_count  = popcount(bullet_active & bullet_owner);
        p1_elig   = p1_pend && (p1_count < 4'(MAX_PER_PLAYER)) && any_free;
        p2_elig   = p2_pend && (p2_count < 4'(MAX_PER_PLAYER)) && any_free;
        any_elig  = p1_elig || p2_elig;
        pick      = (p1_elig && p2_elig) ? ~rr_last : p2_elig;
        pick_x    = pick ? p2_x : p1_x;
        pick_y    = pick ? p2_y : p1_y;
        pick_dir  = pick ? p2_pend_dir : p1_pend_dir;
        pose      = calc_spawn(pick_x, pick_y, pick_dir);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // FSM next state; ARB falls back to IDLE if eligibility vanished or the pose is off-grid
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (any_elig) state_next = ST_ARB;
            ST_ARB:    state_next = (any_elig && pose.ok) ? ST_SPAWN : ST_IDLE;
            ST_SPAWN:  if (spawn_ready) state_next = ST_SETTLE;
            ST_SETTLE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // FSM outputs and per-player control strobes
    always_comb begin
        spawn_valid  = (state == ST_SPAWN);
        handshake    = spawn_valid && spawn_ready;
        arb_load     = (state == ST_ARB) && any_elig && pose.ok;
        p1_pose_drop = (state == ST_ARB) && any_elig && !pose.ok && !pick;
        p2_pose_drop = (state == ST_ARB) && any_elig && !pose.ok && pick;
        p1_busy      = ((state == ST_ARB) && any_elig && !pick) || (spawn_valid && !spawn_owner);
        p2_busy      = ((state == ST_ARB) && any_elig && pick) || (spawn_valid && spawn_owner);
        p1_grant     = handshake && !spawn_owner;
        p2_grant     = handshake && spawn_owner;
    end

    // Spawn payload capture in ARB; owner table and round-robin update on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            spawn_slot   <= 3'd0;
            spawn_x      <= 8'd0;
            spawn_y      <= 8'd0;
            spawn_dir    <= 2'd0;
            spawn_owner  <= 1'b0;
            bullet_owner <= 8'd0;
            rr_last      <= 1'b1;
        end else begin
            if (arb_load) begin
                spawn_slot  <= free_slot;
                spawn_x     <= pose.x;
                spawn_y     <= pose.y;
                spawn_dir   <= pick_dir;
                spawn_owner <= pick;
            end
            if (handshake) begin
                bullet_owner[spawn_slot] <= spawn_owner;
                rr_last                  <= spawn_owner;
            end
        end
    end

endmodule

// File: tb/tb_bullet_slot_arbiter.sv
// Directed bench for bullet_slot_arbiter with hand-computed expectations.
// Inputs change #1 after posedge; outputs are sampled at the same point.
// Bench acts as the bullet engine by setting bullet_active bits after each handshake.
module tb_bullet_slot_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       game_tick = 1'b0;
    logic       p1_fire = 1'b0, p2_fire = 1'b0;
    logic [7:0] p1_x = 8'd10, p1_y = 8'd20, p2_x = 8'd100, p2_y = 8'd50;
    logic [1:0] p1_dir = 2'd1, p2_dir = 2'd3;
    logic       p1_alive = 1'b1, p2_alive = 1'b1;
    logic [7:0] bullet_active = 8'd0;
    logic       spawn_valid;
    logic       spawn_ready = 1'b1;
    logic [2:0] spawn_slot;
    logic [7:0] spawn_x, spawn_y;
    logic [1:0] spawn_dir;
    logic [7:0] bullet_owner;
    logic       p1_ack, p2_ack, p1_drop, p2_drop;

    int vectors = 0;
    int miscompares = 0;

    bullet_slot_arbiter dut (
        .clk(clk), .rst(rst), .game_tick(game_tick),
        .p1_fire(p1_fire), .p2_fire(p2_fire),
        .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
        .p1_dir(p1_dir), .p2_dir(p2_dir),
        .p1_alive(p1_alive), .p2_alive(p2_alive),
        .bullet_active(bullet_active),
        .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
        .spawn_slot(spawn_slot), .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dir(spawn_dir),
        .bullet_owner(bullet_owner),
        .p1_ack(p1_ack), .p2_ack(p2_ack), .p1_drop(p1_drop), .p2_drop(p2_drop)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            game_tick = 1'b1;
            step();
            game_tick = 1'b0;
        end
    endtask

    // Fire pulse held for one cycle; returns in the cycle after the pulse
    task automatic fire_pulse(input logic f1, input logic f2);
        p1_fire = f1;
        p2_fire = f2;
        step();
        p1_fire = 1'b0;
        p2_fire = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++; if (spawn_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", spawn_valid); end
        vectors++; if ({spawn_slot, spawn_x, spawn_y, spawn_dir} !== 21'd0) begin miscompares++; $display("FAIL reset_payload: got %h want 0", {spawn_slot, spawn_x, spawn_y, spawn_dir}); end
        vectors++; if (bullet_owner !== 8'h00) begin miscompares++; $display("FAIL reset_owner: got %h want 00", bullet_owner); end
        vectors++; if ({p1_ack, p2_ack, p1_drop, p2_drop} !== 4'b0) begin miscompares++; $display("FAIL reset_pulses: got %b want 0000", {p1_ack, p2_ack, p1_drop, p2_drop}); end
        rst = 1'b0;
        step();
    endtask

    // Both players fire together twice; rr_last=P2 after each round so P1 leads both times
    task automatic test_both_fire();
        int base;
        for (int r = 0; r < 2; r++) begin
            base = r * 2;
            fire_pulse(1'b1, 1'b1);
            step();
            vectors++; if (spawn_valid !== 1'b0) begin miscompares++; $display("FAIL both_early_valid r%0d: got %b want 0", r, spawn_valid); end
            step();
            vectors++; if ({spawn_valid, p1_ack, p2_ack} !== 3'b110) begin miscompares++; $display("FAIL both_first_ack r%0d: got %b want 110", r, {spawn_valid, p1_ack, p2_ack}); end
            vectors++; if ({spawn_slot, spawn_x, spawn_y, spawn_dir} !== {3'(base), 8'd13, 8'd21, 2'd1}) begin miscompares++; $display("FAIL both_first_payload r%0d: got slot %0d (%0d,%0d) dir %0d want slot %0d (13,21) dir 1", r, spawn_slot, spawn_x, spawn_y, spawn_dir, base); end
            step();
            bullet_active[base] = 1'b1;
            vectors++; if (spawn_valid !== 1'b0) begin miscompares++; $display("FAIL both_settle_valid r%0d: got %b want 0", r, spawn_valid); end
            step();
            step();
            step();
            vectors++; if ({spawn_valid, p1_ack, p2_ack} !== 3'b101) begin miscompares++; $display("FAIL both_second_ack r%0d: got %b want 101", r, {spawn_valid, p1_ack, p2_ack}); end
            vectors++; if ({spawn_slot, spawn_x, spawn_y, spawn_dir} !== {3'(base + 1), 8'd98, 8'd51, 2'd3}) begin miscompares++; $display("FAIL both_second_payload r%0d: got slot %0d (%0d,%0d) dir %0d want slot %0d (98,51) dir 3", r, spawn_slot, spawn_x, spawn_y, spawn_dir, base + 1); end
            step();
            bullet_active[base + 1] = 1'b1;
            vectors++; if (bullet_owner !== ((r == 0) ? 8'h02 : 8'h0A)) begin miscompares++; $display("FAIL both_owner r%0d: got %h want %h", r, bullet_owner, (r == 0) ? 8'h02 : 8'h0A); end
            ticks(12);
        end
    endtask

    // Single P1 fire, all slots free (stale owners remain), spawn_valid/ack at t+3
    task automatic test_single_fire();
        bullet_active = 8'h00;
        fire_pulse(1'b1, 1'b0);
        vectors++; if (spawn_valid !== 1'b0) begin miscompares++; $display("FAIL single_t1_valid: got %b want 0", spawn_valid); end
        step();
        vectors++; if (spawn_valid !== 1'b0) begin miscompares++; $display("FAIL single_t2_valid: got %b want 0", spawn_valid); end
        step();
        vectors++; if ({spawn_valid, p1_ack, p2_ack} !== 3'b110) begin miscompares++; $display("FAIL single_t3_ack: got %b want 110", {spawn_valid, p1_ack, p2_ack}); end
        vectors++; if ({spawn_slot, spawn_x, spawn_y, spawn_dir} !== {3'd0, 8'd13, 8'd21, 2'd1}) begin miscompares++; $display("FAIL single_payload: got slot %0d (%0d,%0d) dir %0d want slot 0 (13,21) dir 1", spawn_slot, spawn_x, spawn_y, spawn_dir); end
        step();
        bullet_active = 8'h01;
        vectors++; if (bullet_owner !== 8'h0A) begin miscompares++; $display("FAIL single_owner: got %h want 0A", bullet_owner); end
        ticks(12);
    endtask

    // Last grant was P1, so a simultaneous pair now serves P2 first
    task automatic test_back_to_back();
        fire_pulse(1'b1, 1'b1);
        step();
        step();
        vectors++; if ({p1_ack, p2_ack, spawn_slot, spawn_x} !== {1'b0, 1'b1, 3'd1, 8'd98}) begin miscompares++; $display("FAIL b2b_first: got ack %b%b slot %0d x %0d want ack 01 slot 1 x 98", p1_ack, p2_ack, spawn_slot, spawn_x); end
        step();
        bullet_active = 8'h03;
        step();
        step();
        step();
        vectors++; if ({p1_ack, p2_ack, spawn_slot, spawn_x} !== {1'b1, 1'b0, 3'd2, 8'd13}) begin miscompares++; $display("FAIL b2b_second: got ack %b%b slot %0d x %0d want ack 10 slot 2 x 13", p1_ack, p2_ack, spawn_slot, spawn_x); end
        step();
        bullet_active = 8'h07;
        vectors++; if (bullet_owner !== 8'h0A) begin miscompares++; $display("FAIL b2b_owner: got %h want 0A", bullet_owner); end
        ticks(12);
    endtask

    // Build up 4 active P2 bullets, then a fifth request must time out after 16 ticks
    task automatic test_cap_timeout();
        int slot;
        bullet_active = 8'h0A;
        for (int k = 0; k < 2; k++) begin
            slot = (k == 0) ? 0 : 2;
            fire_pulse(1'b0, 1'b1);
            step();
            step();
            vectors++; if ({p2_ack, spawn_slot} !== {1'b1, 3'(slot)}) begin miscompares++; $display("FAIL cap_fill k%0d: got ack %b slot %0d want ack 1 slot %0d", k, p2_ack, spawn_slot, slot); end
            step();
            bullet_active[slot] = 1'b1;
            ticks(12);
        end
        vectors++; if (bullet_owner !== 8'h0F) begin miscompares++; $display("FAIL cap_owner: got %h want 0F", bullet_owner); end
        fire_pulse(1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            game_tick = 1'b1;
            vectors++; if ({spawn_valid, p2_drop} !== 2'b00) begin miscompares++; $display("FAIL cap_wait tick%0d: got valid,drop %b want 00", i, {spawn_valid, p2_drop}); end
            step();
        end
        game_tick = 1'b0;
        vectors++; if (p2_drop !== 1'b1) begin miscompares++; $display("FAIL cap_timeout_drop: got %b want 1", p2_drop); end
        step();
        vectors++; if ({p2_drop, p1_drop} !== 2'b00) begin miscompares++; $display("FAIL cap_drop_once: got %b want 00", {p2_drop, p1_drop}); end
    endtask

    // Cooldown boundary: 5 and 11 ticks after a grant the fire is ignored, 12 ticks grants
    task automatic test_cooldown();
        fire_pulse(1'b1, 1'b0);
        step();
        step();
        vectors++; if ({p1_ack, spawn_slot} !== {1'b1, 3'd4}) begin miscompares++; $display("FAIL cd_first: got ack %b slot %0d want ack 1 slot 4", p1_ack, spawn_slot); end
        step();
        bullet_active = 8'h1F;
        for (int phase = 0; phase < 2; phase++) begin
            ticks((phase == 0) ? 5 : 6);
            fire_pulse(1'b1, 1'b0);
            for (int c = 0; c < 6; c++) begin
                vectors++; if ({spawn_valid, p1_ack} !== 2'b00) begin miscompares++; $display("FAIL cd_ignored p%0d c%0d: got valid,ack %b want 00", phase, c, {spawn_valid, p1_ack}); end
                step();
            end
        end
        ticks(1);
        fire_pulse(1'b1, 1'b0);
        step();
        step();
        vectors++; if ({p1_ack, spawn_slot} !== {1'b1, 3'd5}) begin miscompares++; $display("FAIL cd_regrant: got ack %b slot %0d want ack 1 slot 5", p1_ack, spawn_slot); end
        step();
        bullet_active = 8'h3F;
        vectors++; if (bullet_owner !== 8'h0F) begin miscompares++; $display("FAIL cd_owner: got %h want 0F", bullet_owner); end
        ticks(12);
    endtask

    // Off-grid spawn poses are dropped in ARB without raising spawn_valid
    task automatic test_pose_drop();
        logic [7:0] tx [3];
        logic [7:0] ty [3];
        logic [1:0] td [3];
        tx[0] = 8'd1;   ty[0] = 8'd0;  td[0] = 2'd0;   // up: y-2 < 0
        tx[1] = 8'd1;   ty[1] = 8'd5;  td[1] = 2'd3;   // left: x-2 < 0
        tx[2] = 8'd253; ty[2] = 8'd10; td[2] = 2'd1;   // right: x+3 = 256
        for (int k = 0; k < 3; k++) begin
            p1_x = tx[k]; p1_y = ty[k]; p1_dir = td[k];
            fire_pulse(1'b1, 1'b0);
            vectors++; if (p1_drop !== 1'b0) begin miscompares++; $display("FAIL pose_t1 k%0d: got drop %b want 0", k, p1_drop); end
            step();
            vectors++; if ({p1_drop, spawn_valid} !== 2'b10) begin miscompares++; $display("FAIL pose_drop k%0d: got drop,valid %b want 10", k, {p1_drop, spawn_valid}); end
            step();
            vectors++; if ({p1_drop, spawn_valid} !== 2'b00) begin miscompares++; $display("FAIL pose_after k%0d: got drop,valid %b want 00", k, {p1_drop, spawn_valid}); end
        end
        p1_x = 8'd10; p1_y = 8'd20; p1_dir = 2'd1;
    endtask

    // Stall in SPAWN with ticks running (no timeout, payload stable), then reset mid-SPAWN
    task automatic test_stall_reset();
        p1_x = 8'd50; p1_y = 8'd60; p1_dir = 2'd2;
        spawn_ready = 1'b0;
        fire_pulse(1'b1, 1'b0);
        step();
        step();
        for (int c = 0; c < 20; c++) begin
            game_tick = 1'b1;
            vectors++; if ({spawn_valid, spawn_slot, spawn_x, spawn_y, spawn_dir} !== {1'b1, 3'd6, 8'd50, 8'd64, 2'd2}) begin miscompares++; $display("FAIL stall_payload c%0d: got valid %b slot %0d (%0d,%0d) dir %0d want 1 slot 6 (50,64) dir 2", c, spawn_valid, spawn_slot, spawn_x, spawn_y, spawn_dir); end
            vectors++; if ({p1_ack, p1_drop} !== 2'b00) begin miscompares++; $display("FAIL stall_pulses c%0d: got ack,drop %b want 00", c, {p1_ack, p1_drop}); end
            step();
        end
        game_tick = 1'b0;
        rst = 1'b1;
        step();
        vectors++; if (spawn_valid !== 1'b0) begin miscompares++; $display("FAIL rst_spawn_valid: got %b want 0", spawn_valid); end
        vectors++; if ({spawn_slot, spawn_x, spawn_y, spawn_dir, bullet_owner} !== 29'd0) begin miscompares++; $display("FAIL rst_spawn_outputs: got %h want 0", {spawn_slot, spawn_x, spawn_y, spawn_dir, bullet_owner}); end
        vectors++; if ({p1_ack, p2_ack, p1_drop, p2_drop} !== 4'b0) begin miscompares++; $display("FAIL rst_spawn_pulses: got %b want 0000", {p1_ack, p2_ack, p1_drop, p2_drop}); end
        rst = 1'b0;
        spawn_ready = 1'b1;
        step();
    endtask

    // Dying with a pending request drops it; firing while dead is ignored
    task automatic test_alive_drop();
        bullet_active = 8'hFF;
        fire_pulse(1'b0, 1'b1);
        vectors++; if (p2_drop !== 1'b0) begin miscompares++; $display("FAIL alive_pend: got drop %b want 0", p2_drop); end
        step();
        p2_alive = 1'b0;
        #1;
        vectors++; if ({p2_drop, spawn_valid} !== 2'b10) begin miscompares++; $display("FAIL alive_drop: got drop,valid %b want 10", {p2_drop, spawn_valid}); end
        step();
        vectors++; if (p2_drop !== 1'b0) begin miscompares++; $display("FAIL alive_drop_once: got %b want 0", p2_drop); end
        fire_pulse(1'b0, 1'b1);
        step();
        vectors++; if (p2_drop !== 1'b0) begin miscompares++; $display("FAIL dead_fire: got drop %b want 0", p2_drop); end
        p2_alive = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, want finish within time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_both_fire();
        test_single_fire();
        test_back_to_back();
        test_cap_timeout();
        test_cooldown();
        test_pose_drop();
        test_stall_reset();
        test_alive_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
